// File: rtl/mem_responder.sv
// Byte-addressed little-endian memory responder with a request/response handshake and WAIT_CYCLES latency.
// Optional macro MEM_RESPONDER_MISALIGNED_EN: serve misaligned in-range halfword/word accesses byte-wise.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, unsigned_q;
    logic [1:0]        width_q;
    logic [31:0]       addr_q, wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [7:0]        mem [MEM_BYTES];

    logic              commit;
    logic              a_write, a_unsigned;
    logic [1:0]        a_width;
    logic [31:0]       a_addr, a_wdata;
    logic [ADDR_WIDTH-1:0] base;
    logic [3:0]        be;
    logic [2:0]        nbytes;
    logic [32:0]       last;
    logic              oor, misalign, err;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_val;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                cnt_d   = '0;
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = RESP;
                  else cnt_d = cnt_q + 4'd1;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit = (state_q != RESP) && (state_d == RESP);

    // With zero wait states the commit edge is the accepting edge, so use the live request fields.
    always_comb begin
        if (state_q == IDLE) begin
            a_write = req_write;  a_unsigned = req_unsigned;  a_width = req_width;
            a_addr  = req_addr;   a_wdata    = req_wdata;
        end else begin
            a_write = write_q;    a_unsigned = unsigned_q;    a_width = width_q;
            a_addr  = addr_q;     a_wdata    = wdata_q;
        end
    end

    always_comb begin
        case (a_width)
            2'd0:    begin be = 4'b0001; nbytes = 3'd1; end
            2'd1:    begin be = 4'b0011; nbytes = 3'd2; end
            2'd2:    begin be = 4'b1111; nbytes = 3'd4; end
            default: begin be = 4'b0000; nbytes = 3'd0; end
        endcase
        base = a_addr[ADDR_WIDTH-1:0];
        last = {1'b0, a_addr} + 33'(nbytes) - 33'd1;
        oor  = (last[32:ADDR_WIDTH] != '0);
`ifdef MEM_RESPONDER_MISALIGNED_EN
        misalign = 1'b0;
`else
        misalign = ((a_width == 2'd1) && a_addr[0]) ||
                   ((a_width == 2'd2) && (a_addr[1:0] != 2'b00));
`endif
        err = (a_width == 2'd3) || oor || misalign;
    end

    always_comb begin
        b0 = mem[base];
        b1 = mem[base + ADDR_WIDTH'(1)];
        b2 = mem[base + ADDR_WIDTH'(2)];
        b3 = mem[base + ADDR_WIDTH'(3)];
        case (a_width)
            2'd0:    load_val = {{24{~a_unsigned & b0[7]}}, b0};
            2'd1:    load_val = {{16{~a_unsigned & b1[7]}}, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
        rdata_d = rdata_q;
        error_d = error_q;
        if (commit) begin
            error_d = err;
            rdata_d = (err || a_write) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            width_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (state_q == IDLE && req_valid) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                width_q    <= req_width;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
        end
    end

    // Memory contents survive reset; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && commit && a_write && !err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) mem[base + ADDR_WIDTH'(k)] <= a_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: byte-array reference model, per-cycle response compare, literal pins.
module tb_mem_responder;
    localparam int unsigned AW = 10;
    localparam int unsigned WC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  model_m [1 << AW];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_rdata;
    logic        exp_error;
    logic        p_write;
    logic [1:0]  p_width;
    logic [31:0] p_addr, p_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    function automatic int unsigned nbytes_of(input logic [1:0] w);
        return (w == 2'd3) ? 0 : (1 << w);
    endfunction

    function automatic void model_eval(input logic wr, input logic [1:0] w, input logic uns,
                                       input logic [31:0] addr,
                                       output logic [31:0] rd, output logic er);
        int unsigned n;
        longint unsigned la;
        logic [31:0] v;
        n  = nbytes_of(w);
        la = longint'(addr);
        er = (w == 2'd3) || (la + longint'(n) > longint'(1 << AW));
`ifndef MEM_RESPONDER_MISALIGNED_EN
        if (n != 0 && (addr % n) != 0) er = 1'b1;
`endif
        rd = '0;
        if (!er && !wr) begin
            v = '0;
            for (int k = 0; k < int'(n); k++) v[8*k +: 8] = model_m[int'(addr) + k];
            if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        dut.mem[a] = v;
        model_m[a] = v;
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            chk("resp_expected", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_error", 32'(resp_error), 32'(exp_error));
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] w, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int unsigned guard = 0;
        req_valid = 1'b1; req_write = wr; req_width = w; req_unsigned = uns;
        req_addr = addr;  req_wdata = wd;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        chk("req_ready_at_issue", 32'(req_ready), 32'd1);
        @(posedge clk);
        model_eval(wr, w, uns, addr, exp_rdata, exp_error);
        p_write = wr; p_width = w; p_addr = addr; p_wdata = wd;
        exp_valid = 1'b1;
    endtask

    task automatic xact(input logic wr, input logic [1:0] w, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int stall, input bit poke_req,
                        input bit do_pin, input logic [31:0] pin_rd, input logic pin_err);
        int lat;
        issue(wr, w, uns, addr, wd);
        if (do_pin) begin
            chk("pin_model_rdata", exp_rdata, pin_rd);
            chk("pin_model_error", 32'(exp_error), 32'(pin_err));
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'h0000_0155;
        lat = 1;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(WC + 1));
        if (do_pin) chk("pin_dut_rdata", resp_rdata, pin_rd);
        for (int i = 0; i < stall; i++) begin
            if (poke_req && i == 2) begin
                req_valid = 1'b1; req_write = 1'b1; req_width = 2'd2;
                req_addr = 32'd400; req_wdata = 32'hDEAD_BEEF;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        exp_valid = 1'b0;
        if (p_write && !exp_error)
            for (int k = 0; k < int'(nbytes_of(p_width)); k++)
                model_m[int'(p_addr) + k] = p_wdata[8*k +: 8];
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) poke(i, 8'(i * 37 + 11));
        poke(128, 8'h58); poke(129, 8'h00); poke(130, 8'h00); poke(131, 8'h00);
        poke(200, 8'h88); poke(201, 8'h80);
        poke(300, 8'hDD); poke(301, 8'hCC); poke(302, 8'hBB); poke(303, 8'hAA);
        for (int i = 0; i < 6; i++) poke(32'h100 + i, 8'(8'hF0 + i));
        for (int i = 0; i < 4; i++) poke(32'h200 + i, 8'(8'h10 + i));
        poke(32'h3FF, 8'hA5);
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_error", 32'(resp_error), 32'd0);
        rst = 1'b0;

        xact(1'b0, 2'd2, 1'b0, 32'd128, '0, 0, 0, 1, 32'h0000_0058, 1'b0);
        xact(1'b0, 2'd0, 1'b0, 32'd200, '0, 0, 0, 1, 32'hFFFF_FF88, 1'b0);
        xact(1'b0, 2'd0, 1'b1, 32'd200, '0, 0, 0, 1, 32'h0000_0088, 1'b0);
        xact(1'b0, 2'd1, 1'b0, 32'd200, '0, 0, 0, 1, 32'hFFFF_8088, 1'b0);
        xact(1'b0, 2'd1, 1'b1, 32'd200, '0, 0, 0, 1, 32'h0000_8088, 1'b0);
        xact(1'b1, 2'd1, 1'b0, 32'd300, 32'hFFFF_1234, 5, 1, 1, 32'h0, 1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'd300, '0, 5, 1, 1, 32'hAABB_1234, 1'b0);
        for (int k = 0; k < 4; k++) chk("ignored_store_mem", 32'(dut.mem[400 + k]), 32'(model_m[400 + k]));

        xact(1'b0, 2'd2, 1'b0, 32'h3FE, '0, 0, 0, 1, 32'h0, 1'b1);
        xact(1'b0, 2'd3, 1'b0, 32'h010, '0, 0, 0, 1, 32'h0, 1'b1);
        xact(1'b0, 2'd0, 1'b0, 32'h400, '0, 0, 0, 1, 32'h0, 1'b1);
        xact(1'b0, 2'd0, 1'b1, 32'h3FF, '0, 0, 0, 1, 32'h0000_00A5, 1'b0);
`ifdef MEM_RESPONDER_MISALIGNED_EN
        xact(1'b1, 2'd2, 1'b0, 32'h101, 32'h1122_3344, 1, 0, 1, 32'h0, 1'b0);
        chk("mis_store_b0", 32'(dut.mem[32'h101]), 32'h44);
        chk("mis_store_b3", 32'(dut.mem[32'h104]), 32'h11);
`else
        xact(1'b1, 2'd2, 1'b0, 32'h101, 32'h1122_3344, 1, 0, 1, 32'h0, 1'b1);
        chk("mis_store_b0", 32'(dut.mem[32'h101]), 32'hF1);
        chk("mis_store_b3", 32'(dut.mem[32'h104]), 32'hF4);
`endif
        chk("mis_store_edge", 32'(dut.mem[32'h105]), 32'hF5);
        xact(1'b0, 2'd1, 1'b0, 32'd201, '0, 0, 0, 0, 32'h0, 1'b0);
        xact(1'b1, 2'd2, 1'b0, 32'h204, 32'h0BAD_CAFE, 0, 0, 0, 32'h0, 1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'h204, '0, 2, 0, 1, 32'h0BAD_CAFE, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1; exp_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk("rst_mid_mem", 32'(dut.mem[32'h200 + k]), 32'(8'h10 + k));
        xact(1'b0, 2'd2, 1'b0, 32'h200, '0, 0, 0, 1, 32'h1312_1110, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-addressed, little-endian data/instruction memory that serves load and store requests from the multicycle control FSM.
- It is the responder end of the control's memory interface: control issues fetch, lw and sw requests, and this block returns read data or commits write data.
- Request/response handshake with a configurable number of wait states, so the control FSM is exercised against non-zero memory latency.

Parameters:
- ADDR_WIDTH, 10, byte address bits actually decoded; memory size is 2**ADDR_WIDTH bytes.
- WAIT_CYCLES, 1, wait states inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_width  input  2  0 = 8 bits, 1 = 16 bits, 2 = 32 bits, 3 = reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes are used for narrow stores.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator consumes the response.
- resp_rdata  output  32  load data, extended to 32 bits.
- resp_error  output  1  request rejected.

Behaviour:
- Clocking/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter 0.
- Reset does not clear memory contents; the bench preloads them hierarchically.
- Reset mid-transaction abandons the transaction. A store whose commit edge has not yet occurred is not written.

State machine:
- IDLE: req_ready=1. On req_valid&&req_ready, latch all req_* fields and go to WAIT, or straight to RESP if WAIT_CYCLES=0. req_ready drops the cycle after acceptance.
- WAIT: count WAIT_CYCLES edges, then go to RESP.
- Commit: on the edge entering RESP, the memory access happens. Loads sample memory; stores write the selected bytes.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge.
- RESP: resp_valid=1; resp_rdata and resp_error are held stable until resp_valid&&resp_ready, then return to IDLE.
- Back-to-back: a new request can be accepted in the first cycle IDLE is re-entered. There is no acceptance while in RESP; only one transaction is outstanding.

Data rules:
- Little-endian: byte k of the word lives at addr+k.
- Loads: an 8/16-bit load fills bits [7:0]/[15:0], then sign- or zero-extends per req_unsigned. A 32-bit load ignores req_unsigned.
- Stores: write only 1/2/4 bytes; the other bytes are unchanged. resp_rdata=0 for stores.

Error conditions (resp_error=1, no memory write, resp_rdata=0):
- req_width=3.
- Out of range: req_addr + bytes - 1 >= 2**ADDR_WIDTH, or any req_addr bits above ADDR_WIDTH-1 set.
- Misaligned access, when the optional feature is disabled.
- An error response still follows normal latency and handshake.
- A request with req_valid dropped before acceptance is not a transaction. Inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_RESPONDER_MISALIGNED_EN.
- Defined: halfword/word accesses at any in-range byte address are served byte-wise with the same latency.
- Not defined: 16-bit accesses with addr[0]≠0 and 32-bit accesses with addr[1:0]≠0 return resp_error=1 with no write.

Test Plan:
- Aligned word load: preload mem[128..131]=58,00,00,00; load width 2 at addr 128, WAIT_CYCLES=1 -> resp_valid exactly 2 edges after accept, resp_rdata=0x00000058, resp_error=0.
- Sign/zero extension: mem[200]=0x88; byte load signed -> 0xFFFFFF88; unsigned -> 0x00000088. Half load at 200 with mem[201]=0x80 -> 0xFFFF8088 signed.
- Narrow store: word at 300 = 0xAABBCCDD; half store of 0x1234 at 300, then word load at 300 -> 0xAABB1234.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout; a req_valid pulse in that window is ignored.
- Errors: word load at 0x3FE with ADDR_WIDTH=10 -> resp_error=1, rdata=0. req_width=3 -> error. Word store at 0x101 without the macro -> error and memory unchanged; with the macro -> bytes 0x101..0x104 written.
- Reset mid-operation: assert rst during WAIT of a store -> next cycle req_ready=1, resp_valid=0, and the target bytes remain unchanged.
